// File: rtl/ofdm_frame_deframer_pkg.sv
// ofdm_frame_deframer shared definitions
// FCH bit map, state encoding, default frame geometry
package ofdm_frame_deframer_pkg;

  localparam int DEF_DATA_SIZE    = 16;
  localparam int DEF_SYMBOLS_SIZE = 256;
  localparam int DEF_CP_LENGHT    = 8;
  localparam int DEF_FCH_TIMEOUT  = 4;

  localparam int B0_REP0   = 7;
  localparam int B0_RSVD   = 6;
  localparam int B0_BM_HI  = 5;
  localparam int B1_FS_HI  = 7;
  localparam int B1_FS_LO  = 4;
  localparam int B1_CI_HI  = 3;
  localparam int B1_CI_LO  = 1;
  localparam int B1_REP1   = 0;
  localparam int B2_RSV_HI = 7;
  localparam int B2_RSV_LO = 4;
  localparam int B2_FS_HI  = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [7:0] frame_size;
    logic [2:0] coding;
    logic [1:0] repetition;
    logic [5:0] bitmap;
  } fch_t;

  function automatic logic b0_bad(input logic [7:0] b);
    return b[B0_RSVD];
  endfunction

  function automatic logic b2_bad(input logic [7:0] b);
    return |b[B2_RSV_HI:B2_RSV_LO];
  endfunction

endpackage

// File: rtl/ofdm_frame_deframer_if.sv
// ofdm_frame_deframer sample streams
// Time-domain input and FFT-side output bundle
interface ofdm_frame_deframer_if #(
  parameter int DATA_SIZE = 16
);
  logic                 in_valid;
  logic [DATA_SIZE-1:0] in_data_i;
  logic [DATA_SIZE-1:0] in_data_q;
  logic                 fft_valid;
  logic                 fft_first;
  logic                 fft_last;
  logic [DATA_SIZE-1:0] fft_data_i;
  logic [DATA_SIZE-1:0] fft_data_q;
  logic [7:0]           symbol_index;

  modport master (
    output in_valid, in_data_i, in_data_q,
    input  fft_valid, fft_first, fft_last,
    input  fft_data_i, fft_data_q, symbol_index
  );

  modport slave (
    input  in_valid, in_data_i, in_data_q,
    output fft_valid, fft_first, fft_last,
    output fft_data_i, fft_data_q, symbol_index
  );
endinterface

// File: rtl/ofdm_frame_deframer_fch.sv
// ofdm_fch_parser: FCH byte counter and field latches
// Flags a reserved-bit violation on the accepting cycle
module ofdm_fch_parser
  import ofdm_frame_deframer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       fch_valid,
  input  logic [7:0] fch_data,
  output fch_t       fch,
  output logic       fch_ok,
  output logic       rsvd_err
);

  logic [1:0] cnt_q, cnt_d;
  fch_t       fch_q, fch_d;
  logic       ok_q, ok_d;
  logic       take;

  // accept the first three bytes of a frame and latch fields
  always_comb begin
    cnt_d    = cnt_q;
    fch_d    = fch_q;
    ok_d     = ok_q;
    rsvd_err = 1'b0;
    take     = en && fch_valid && (cnt_q != 2'd3);
    if (clr) begin
      cnt_d = '0;
      fch_d = '0;
      ok_d  = 1'b0;
    end else if (take) begin
      cnt_d = cnt_q + 2'd1;
      unique case (1'b1)
        cnt_q == 2'd0: begin
          fch_d.repetition[0] = fch_data[B0_REP0];
          fch_d.bitmap        = fch_data[B0_BM_HI:0];
          rsvd_err            = b0_bad(fch_data);
        end
        cnt_q == 2'd1: begin
          fch_d.frame_size[3:0] = fch_data[B1_FS_HI:B1_FS_LO];
          fch_d.coding          = fch_data[B1_CI_HI:B1_CI_LO];
          fch_d.repetition[1]   = fch_data[B1_REP1];
        end
        default: begin
          fch_d.frame_size[7:4] = fch_data[B2_FS_HI:0];
          rsvd_err              = b2_bad(fch_data);
          ok_d                  = !b2_bad(fch_data);
        end
      endcase
    end
  end

  // parser state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      fch_q <= '0;
      ok_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      fch_q <= fch_d;
      ok_q  <= ok_d;
    end
  end

  assign fch    = fch_q;
  assign fch_ok = ok_q;

endmodule

// File: rtl/ofdm_frame_deframer.sv
// ofdm_frame_deframer: CP strip, symbol tagging, frame FSM
// Forwards 256-sample symbols and ends on done/error
module ofdm_frame_deframer
  import ofdm_frame_deframer_pkg::*;
#(
  parameter int DATA_SIZE    = DEF_DATA_SIZE,
  parameter int SYMBOLS_SIZE = DEF_SYMBOLS_SIZE,
  parameter int CP_LENGHT    = DEF_CP_LENGHT,
  parameter int FCH_TIMEOUT  = DEF_FCH_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  ofdm_frame_deframer_if.slave s,
  input  logic       fch_valid,
  input  logic [7:0] fch_data,
  output logic       fch_ok,
  output logic [7:0] frame_size,
  output logic [2:0] coding_indicator,
  output logic [1:0] repetition,
  output logic [5:0] subchannel_bitmap,
  output logic       done_receive,
  output logic       frame_error,
  output logic       o_state_rx
);

  localparam int SLEN = CP_LENGHT + SYMBOLS_SIZE;
  localparam int SW   = $clog2(SLEN);
  localparam logic [SW-1:0] S_FIRST = SW'(CP_LENGHT);
  localparam logic [SW-1:0] S_LAST  = SW'(SLEN - 1);
  localparam logic [7:0]    TMO     = 8'(FCH_TIMEOUT);

  state_e               state_q, state_d;
  logic [SW-1:0]        samp_q, samp_d;
  logic [7:0]           sym_q, sym_d;
  logic                 fv_q, fv_d;
  logic                 ff_q, ff_d;
  logic                 fl_q, fl_d;
  logic [DATA_SIZE-1:0] di_q, di_d;
  logic [DATA_SIZE-1:0] dq_q, dq_d;
  logic [7:0]           idx_q, idx_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 start, run, take;
  logic                 past_end, done_hit, tmo_hit;
  fch_t                 fch;
  logic                 rsvd_err;

  ofdm_fch_parser u_fch (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start),
    .en        (run),
    .fch_valid (fch_valid),
    .fch_data  (fch_data),
    .fch       (fch),
    .fch_ok    (fch_ok),
    .rsvd_err  (rsvd_err)
  );

  // sample/symbol counting, forwarding and frame end decisions
  always_comb begin
    state_d  = state_q;
    samp_d   = samp_q;
    sym_d    = sym_q;
    fv_d     = 1'b0;
    ff_d     = 1'b0;
    fl_d     = 1'b0;
    di_d     = di_q;
    dq_d     = dq_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    start    = (state_q == ST_IDLE) && frame_start;
    run      = (state_q == ST_RUN);
    take     = run && s.in_valid;
    past_end = fch_ok && (sym_q > fch.frame_size);
    if (start) begin
      state_d = ST_RUN;
      samp_d  = s.in_valid ? SW'(1) : '0;
      sym_d   = '0;
    end
    if (take) begin
      if (samp_q == S_LAST) begin
        samp_d = '0;
        if (sym_q != 8'hFF) sym_d = sym_q + 8'd1;
      end else begin
        samp_d = samp_q + SW'(1);
      end
      if (samp_q >= S_FIRST && !past_end) begin
        fv_d  = 1'b1;
        ff_d  = (samp_q == S_FIRST);
        fl_d  = (samp_q == S_LAST);
        di_d  = s.in_data_i;
        dq_d  = s.in_data_q;
        idx_d = sym_q;
      end
    end
    done_hit = run && fch_ok &&
               ({1'b0, sym_d} >= ({1'b0, fch.frame_size} + 9'd1));
    tmo_hit  = run && !fch_ok && (sym_d == TMO);
    if (run && rsvd_err) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end else if (done_hit) begin
      done_d  = 1'b1;
      state_d = ST_IDLE;
    end else if (tmo_hit) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end
  end

  // frame FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      samp_q  <= '0;
      sym_q   <= '0;
      fv_q    <= 1'b0;
      ff_q    <= 1'b0;
      fl_q    <= 1'b0;
      di_q    <= '0;
      dq_q    <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      sym_q   <= sym_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
      fl_q    <= fl_d;
      di_q    <= di_d;
      dq_q    <= dq_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign s.fft_valid        = fv_q;
  assign s.fft_first        = ff_q;
  assign s.fft_last         = fl_q;
  assign s.fft_data_i       = di_q;
  assign s.fft_data_q       = dq_q;
  assign s.symbol_index     = idx_q;
  assign frame_size         = fch.frame_size;
  assign coding_indicator   = fch.coding;
  assign repetition         = fch.repetition;
  assign subchannel_bitmap  = fch.bitmap;
  assign done_receive       = done_q;
  assign frame_error        = err_q;
  assign o_state_rx         = (state_q == ST_RUN);

endmodule

// File: tb/tb_ofdm_frame_deframer.sv
// tb_ofdm_frame_deframer: table plus randomized frames
// Reference stream built from sample positions in the frame
module tb_ofdm_frame_deframer;

  localparam int SL = 264;

  typedef struct {
    logic [7:0] b0, b1, b2;
    bit         send_fch;
    int         nsamp;
    int         gap;
    bit         mid;
    bit         exp_done;
    bit         exp_err;
    int         exp_nfwd;
    logic [7:0] exp_fs;
    logic [2:0] exp_ci;
    logic [1:0] exp_rep;
    logic [5:0] exp_bm;
  } vec_t;

  typedef struct packed {
    logic [31:0] iq;
    logic [7:0]  idx;
    logic        f;
    logic        l;
  } fo_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       fch_valid = 1'b0;
  logic [7:0] fch_data = '0;
  logic       fch_ok;
  logic [7:0] frame_size;
  logic [2:0] coding_indicator;
  logic [1:0] repetition;
  logic [5:0] subchannel_bitmap;
  logic       done_receive;
  logic       frame_error;
  logic       o_state_rx;

  ofdm_frame_deframer_if #(.DATA_SIZE(16)) bus ();

  ofdm_frame_deframer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .frame_start       (frame_start),
    .s                 (bus.slave),
    .fch_valid         (fch_valid),
    .fch_data          (fch_data),
    .fch_ok            (fch_ok),
    .frame_size        (frame_size),
    .coding_indicator  (coding_indicator),
    .repetition        (repetition),
    .subchannel_bitmap (subchannel_bitmap),
    .done_receive      (done_receive),
    .frame_error       (frame_error),
    .o_state_rx        (o_state_rx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_n, err_n, end_cyc;
  fo_t got[$];
  logic [31:0] sent[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.fft_valid)
      got.push_back({bus.fft_data_i, bus.fft_data_q,
                     bus.symbol_index, bus.fft_first, bus.fft_last});
    if (done_receive) begin
      done_n  = done_n + 1;
      end_cyc = cyc;
    end
    if (frame_error) begin
      err_n   = err_n + 1;
      end_cyc = cyc;
    end
  end

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string t);
    chk({t, ".fft"}, {bus.fft_valid, bus.fft_first, bus.fft_last}, 0);
    chk({t, ".data"}, {bus.fft_data_i, bus.fft_data_q}, 0);
    chk({t, ".idx"}, bus.symbol_index, 0);
    chk({t, ".fch"}, {fch_ok, frame_size, coding_indicator,
                      repetition, subchannel_bitmap}, 0);
    chk({t, ".pulse"}, {done_receive, frame_error}, 0);
    chk({t, ".state"}, o_state_rx, 0);
  endtask

  task automatic run_frame(input vec_t v, input string tag,
                           input int rst_at);
    int k, nf, bad, end_k, exp_end;
    fo_t e;
    got.delete();
    sent.delete();
    done_n  = 0;
    err_n   = 0;
    end_cyc = -1;
    exp_end = -2;
    if (v.exp_err && v.send_fch) end_k = 22;
    else if (v.exp_err)          end_k = 4 * SL - 1;
    else                         end_k = (v.exp_nfwd / 256) * SL - 1;
    k = 0;
    while (k < v.nsamp) begin
      @(posedge clk); #1;
      frame_start = 1'b0;
      fch_valid   = 1'b0;
      fch_data    = '0;
      if (k == rst_at) begin
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_idle({tag, ".rst"});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      if (k == 0 || v.gap == 0 || $urandom_range(99) >= v.gap) begin
        bus.in_valid  = 1'b1;
        bus.in_data_i = 16'($urandom);
        bus.in_data_q = 16'($urandom);
        sent.push_back({bus.in_data_i, bus.in_data_q});
        frame_start = (k == 0) || (v.mid && k == 500);
        if (v.send_fch && k >= 20 && k <= 22) begin
          fch_valid = 1'b1;
          fch_data  = (k == 20) ? v.b0 : (k == 21) ? v.b1 : v.b2;
        end
        if (k == end_k) exp_end = cyc + 1;
        k++;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    frame_start  = 1'b0;
    fch_valid    = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    nf  = 0;
    bad = 0;
    for (int j = 0; j < sent.size() && nf < v.exp_nfwd; j++) begin
      if (j % SL >= 8) begin
        e = {sent[j], 8'(j / SL), 1'((j % SL) == 8),
             1'((j % SL) == SL - 1)};
        if (nf >= got.size() || got[nf] != e) bad++;
        nf++;
      end
    end
    chk({tag, ".nfwd"}, got.size(), v.exp_nfwd);
    chk({tag, ".stream"}, bad, 0);
    chk({tag, ".done"}, done_n, v.exp_done);
    chk({tag, ".err"}, err_n, v.exp_err);
    chk({tag, ".endcyc"}, end_cyc, exp_end);
    chk({tag, ".fch_ok"}, fch_ok, v.exp_done);
    chk({tag, ".state"}, o_state_rx, 0);
    if (v.exp_done) begin
      chk({tag, ".fs"}, frame_size, v.exp_fs);
      chk({tag, ".ci"}, coding_indicator, v.exp_ci);
      chk({tag, ".rep"}, repetition, v.exp_rep);
      chk({tag, ".bm"}, subchannel_bitmap, v.exp_bm);
    end
  endtask

  vec_t tbl[6];
  vec_t rv;
  logic [7:0] fs;
  logic [2:0] ci;
  logic [1:0] rep;
  logic [5:0] bm;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data_i = '0;
    bus.in_data_q = '0;
    tbl[0] = '{8'h3F, 8'h21, 8'h00, 1, 792, 0, 0, 1, 0, 768,
               8'd2, 3'd0, 2'b10, 6'h3F};
    tbl[1] = '{8'h80, 8'h0E, 8'h00, 1, 274, 0, 0, 1, 0, 256,
               8'd0, 3'd7, 2'b01, 6'h00};
    tbl[2] = '{8'h05, 8'h31, 8'h10, 1, 300, 0, 0, 0, 1, 15,
               8'd0, 3'd0, 2'b00, 6'h00};
    tbl[3] = '{8'h00, 8'h00, 8'h00, 0, 1076, 0, 0, 0, 1, 1024,
               8'd0, 3'd0, 2'b00, 6'h00};
    tbl[4] = '{8'h3F, 8'h21, 8'h00, 1, 792, 40, 1, 1, 0, 768,
               8'd2, 3'd0, 2'b10, 6'h3F};
    tbl[5] = '{8'h95, 8'h57, 8'h00, 1, 1614, 25, 1, 1, 0, 1536,
               8'd5, 3'd3, 2'b11, 6'h15};
    #2;
    chk_idle("reset");
    #10 rst_n = 1'b1;
    for (int i = 0; i < 6; i++)
      run_frame(tbl[i], $sformatf("vec%0d", i), -1);
    run_frame(tbl[0], "midrst", SL + 100);
    run_frame(tbl[0], "after_rst", -1);
    for (int r = 0; r < 3; r++) begin
      fs  = 8'($urandom_range(0, 3));
      ci  = 3'($urandom);
      rep = 2'($urandom);
      bm  = 6'($urandom);
      rv.b0       = {rep[0], 1'b0, bm};
      rv.b1       = {fs[3:0], ci, rep[1]};
      rv.b2       = {4'h0, fs[7:4]};
      rv.send_fch = 1;
      rv.nsamp    = (int'(fs) + 1) * SL + $urandom_range(0, 40);
      rv.gap      = $urandom_range(0, 50);
      rv.mid      = 1;
      rv.exp_done = 1;
      rv.exp_err  = 0;
      rv.exp_nfwd = (int'(fs) + 1) * 256;
      rv.exp_fs   = fs;
      rv.exp_ci   = ci;
      rv.exp_rep  = rep;
      rv.exp_bm   = bm;
      run_frame(rv, $sformatf("rnd%0d", r), -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
